// File: rtl/branch_predictor.sv
// FETCH-side BEQ/BNE predictor: direct-mapped BTB with 2-bit saturating counters,
// a FETCH->DECODE pending prediction, and mispredict/redirect generation in DECODE.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pcFETC,
  output logic            predTaken,
  output logic [PC_W-1:0] predTarget,
  input  logic            stall,
  input  logic            flush,
  input  logic            brDECO,
  input  logic            brTakenDECO,
  input  logic [PC_W-1:0] brTargetDECO,
  input  logic [PC_W-1:0] pcDECO,
  input  logic [PC_W-1:0] pcPlus4DECO,
  output logic            mispredict,
  output logic [PC_W-1:0] redirectPC,
  output logic [CNT_W-1:0] brCount,
  output logic [CNT_W-1:0] missCount
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = PC_W - IDX_BITS - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];

  logic              pend_valid_q, pend_valid_d;
  logic              pend_taken_q, pend_taken_d;
  logic [PC_W-1:0]   pend_target_q, pend_target_d;
  logic [CNT_W-1:0]  br_count_q, br_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic [IDX_BITS-1:0] fetch_idx_s, dec_idx_s;
  logic [TAG_W-1:0]    fetch_tag_s, dec_tag_s;
  logic                fetch_hit_s, dec_hit_s, resolve_s, mispredict_s;

  logic              wr_en_s;
  logic              ent_valid_d;
  logic [TAG_W-1:0]  ent_tag_d;
  logic [PC_W-1:0]   ent_target_d;
  logic [1:0]        ent_cnt_d;

  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{pcFETC[1:0], pcDECO[1:0]};

  assign fetch_idx_s = pcFETC[IDX_BITS+1:2];
  assign fetch_tag_s = pcFETC[PC_W-1:IDX_BITS+2];
  assign dec_idx_s   = pcDECO[IDX_BITS+1:2];
  assign dec_tag_s   = pcDECO[PC_W-1:IDX_BITS+2];
  assign fetch_hit_s = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
  assign dec_hit_s   = valid_q[dec_idx_s] && (tag_q[dec_idx_s] == dec_tag_s);
  assign resolve_s   = !stall && pend_valid_q;

  always_comb begin
    predTaken  = fetch_hit_s && cnt_q[fetch_idx_s][1];
    predTarget = predTaken ? target_q[fetch_idx_s] : {PC_W{1'b0}};
  end

  // Resolution: wrong direction, wrong target, or a taken prediction on a non-branch.
  always_comb begin
    mispredict_s = resolve_s &&
                   ((brDECO && (brTakenDECO != pend_taken_q)) ||
                    (brDECO && brTakenDECO && pend_taken_q && (pend_target_q != brTargetDECO)) ||
                    (!brDECO && pend_taken_q));
    mispredict   = mispredict_s;
    if (!mispredict_s) begin
      redirectPC = {PC_W{1'b0}};
    end else if (brDECO && brTakenDECO) begin
      redirectPC = brTargetDECO;
    end else begin
      redirectPC = pcPlus4DECO;
    end
  end

  always_comb begin
    wr_en_s      = 1'b0;
    ent_valid_d  = valid_q[dec_idx_s];
    ent_tag_d    = tag_q[dec_idx_s];
    ent_target_d = target_q[dec_idx_s];
    ent_cnt_d    = cnt_q[dec_idx_s];
    if (resolve_s && brDECO) begin
      if (dec_hit_s) begin
        wr_en_s = 1'b1;
        if (brTakenDECO) begin
          ent_target_d = brTargetDECO;
          ent_cnt_d    = (cnt_q[dec_idx_s] == 2'b11) ? 2'b11 : cnt_q[dec_idx_s] + 2'b01;
        end else begin
          ent_cnt_d    = (cnt_q[dec_idx_s] == 2'b00) ? 2'b00 : cnt_q[dec_idx_s] - 2'b01;
        end
      end else if (brTakenDECO) begin
        wr_en_s      = 1'b1;
        ent_valid_d  = 1'b1;
        ent_tag_d    = dec_tag_s;
        ent_target_d = brTargetDECO;
        ent_cnt_d    = 2'b10;
      end else begin
        wr_en_s = 1'b0;
      end
    end else if (resolve_s && pend_taken_q) begin
      // Alias: a non-branch hit a taken entry, so drop that entry.
      wr_en_s     = 1'b1;
      ent_valid_d = 1'b0;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_taken_d  = pend_taken_q;
    pend_target_d = pend_target_q;
    if (flush) begin
      pend_valid_d  = 1'b0;
      pend_taken_d  = 1'b0;
      pend_target_d = {PC_W{1'b0}};
    end else if (!stall) begin
      pend_valid_d  = 1'b1;
      pend_taken_d  = predTaken;
      pend_target_d = predTarget;
    end else begin
      pend_valid_d  = pend_valid_q;
    end
  end

  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (resolve_s && brDECO && (br_count_q != {CNT_W{1'b1}})) begin
      br_count_d = br_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      br_count_d = br_count_q;
    end
    if (mispredict_s && (miss_count_q != {CNT_W{1'b1}})) begin
      miss_count_d = miss_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  assign brCount   = br_count_q;
  assign missCount = miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= {PC_W{1'b0}};
        cnt_q[i]    <= 2'b01;
      end
      pend_valid_q  <= 1'b0;
      pend_taken_q  <= 1'b0;
      pend_target_q <= {PC_W{1'b0}};
      br_count_q    <= {CNT_W{1'b0}};
      miss_count_q  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        valid_q[dec_idx_s]  <= ent_valid_d;
        tag_q[dec_idx_s]    <= ent_tag_d;
        target_q[dec_idx_s] <= ent_target_d;
        cnt_q[dec_idx_s]    <= ent_cnt_d;
      end
      pend_valid_q  <= pend_valid_d;
      pend_taken_q  <= pend_taken_d;
      pend_target_q <= pend_target_d;
      br_count_q    <= br_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations are queued per cycle and
// popped against the DUT outputs sampled half a cycle away from the rising edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcFETC;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        stall, flush, brDECO, brTakenDECO;
  logic [31:0] brTargetDECO, pcDECO, pcPlus4DECO;
  logic        mispredict;
  logic [31:0] redirectPC;
  logic [15:0] brCount, missCount;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .pcFETC       (pcFETC),
    .predTaken    (predTaken),
    .predTarget   (predTarget),
    .stall        (stall),
    .flush        (flush),
    .brDECO       (brDECO),
    .brTakenDECO  (brTakenDECO),
    .brTargetDECO (brTargetDECO),
    .pcDECO       (pcDECO),
    .pcPlus4DECO  (pcPlus4DECO),
    .mispredict   (mispredict),
    .redirectPC   (redirectPC),
    .brCount      (brCount),
    .missCount    (missCount)
  );

  task automatic drive(input logic [31:0] pf, input logic st, input logic fl,
                       input logic br, input logic tk,
                       input logic [31:0] tg, input logic [31:0] pd);
    pcFETC       = pf;
    stall        = st;
    flush        = fl;
    brDECO       = br;
    brTakenDECO  = tk;
    brTargetDECO = tg;
    pcDECO       = pd;
    pcPlus4DECO  = pd + 32'd4;
  endtask

  task automatic push(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic expect_out(input logic pt, input logic [31:0] ptg, input logic mp,
                            input logic [31:0] rp, input logic [15:0] bc,
                            input logic [15:0] mc);
    push("predTaken",  {31'd0, pt});
    push("predTarget", ptg);
    push("mispredict", {31'd0, mp});
    push("redirectPC", rp);
    push("brCount",    {16'd0, bc});
    push("missCount",  {16'd0, mc});
  endtask

  task automatic cmp(input string step, input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard_empty: observed 0x%0h, nothing expected", step, obs);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s %s: observed 0x%0h expected 0x%0h", step, e.name, obs, e.val);
      end
    end
  endtask

  task automatic compare_out(input string step);
    cmp(step, {31'd0, predTaken});
    cmp(step, predTarget);
    cmp(step, {31'd0, mispredict});
    cmp(step, redirectPC);
    cmp(step, {16'd0, brCount});
    cmp(step, {16'd0, missCount});
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // cold table
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd0, 16'd0); compare_out("reset");
    @(negedge clk);
    // BEQ 0x40 taken -> 0x80 with a cold table
    drive(32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b1, 32'h80, 16'd0, 16'd0); compare_out("cold_taken");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44);
    #1; expect_out(1'b1, 32'h80, 1'b0, 32'h0, 16'd1, 16'd1); compare_out("alloc_hit");
    @(negedge clk);
    // first not-taken: still predicted taken
    drive(32'h48, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b1, 32'h44, 16'd1, 16'd1); compare_out("nt_first");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h48);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd2, 16'd2); compare_out("wnt_lookup");
    @(negedge clk);
    drive(32'h4C, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd2, 16'd2); compare_out("nt_second");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4C);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd3, 16'd2); compare_out("snt_lookup");
    @(negedge clk);
    // retrain 00 -> 01 -> 10 -> 11; lookup sees pre-update contents each cycle
    drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b1, 32'h80, 16'd3, 16'd2); compare_out("train_00");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b1, 32'h80, 16'd4, 16'd3); compare_out("train_01");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h40);
    #1; expect_out(1'b1, 32'h80, 1'b1, 32'h80, 16'd5, 16'd4); compare_out("train_10");
    @(negedge clk);
    // 0x80 shares index 0 with a different tag
    drive(32'h80, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd6, 16'd5); compare_out("tag_miss");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80);
    #1; expect_out(1'b1, 32'h80, 1'b0, 32'h0, 16'd7, 16'd5); compare_out("st_sat");
    @(negedge clk);
    // non-branch aliasing a taken entry
    drive(32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b1, 32'h44, 16'd7, 16'd5); compare_out("alias");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h50);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd7, 16'd6); compare_out("invalidated");
    @(negedge clk);
    drive(32'h54, 1'b0, 1'b0, 1'b1, 1'b1, 32'h90, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b1, 32'h90, 16'd7, 16'd6); compare_out("realloc");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h54);
    #1; expect_out(1'b1, 32'h90, 1'b0, 32'h0, 16'd8, 16'd7); compare_out("realloc_hit");
    @(negedge clk);
    // taken-predicted branch held in DECODE for 3 stalled cycles, wrong target
    for (int i = 0; i < 3; i++) begin
      drive(32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 32'h40);
      #1; expect_out(1'b1, 32'h90, 1'b0, 32'h0, 16'd8, 16'd7); compare_out("stalled");
      @(negedge clk);
    end
    drive(32'h58, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b1, 32'hA0, 16'd8, 16'd7); compare_out("unstall");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h58);
    #1; expect_out(1'b1, 32'hA0, 1'b0, 32'h0, 16'd9, 16'd8); compare_out("single_upd");
    @(negedge clk);
    // flush with stall clears the pending taken prediction
    drive(32'h58, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd9, 16'd8); compare_out("flush_stall");
    @(negedge clk);
    drive(32'h58, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd9, 16'd8); compare_out("after_flush");
    @(negedge clk);
    drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h58);
    #1; expect_out(1'b1, 32'hA0, 1'b0, 32'h0, 16'd9, 16'd8); compare_out("no_upd_flush");
    @(negedge clk);
    // mid-operation reset with a taken prediction pending
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC0, 32'h40);
    #1; expect_out(1'b0, 32'h0, 1'b0, 32'h0, 16'd0, 16'd0); compare_out("mid_reset");

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
